// File: rtl/sc_random_lane_scheduler.sv
// Spawn-window scheduler: opens one window every LEVEL+1 road-scroll events and picks a lane using an 8-bit LFSR.
// The optional pause input is enabled by defining SC_RANDOM_LANE_SCHEDULER_PAUSE_EN.
module sc_random_lane_scheduler #(
    parameter int         LEVEL_W   = 2,
    parameter int         CHANNELS  = 4,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                SC_RANDOM_LANE_SCHEDULER_CLOCK_50,
    input  logic                SC_RANDOM_LANE_SCHEDULER_RESET_InHigh,
    input  logic                SC_RANDOM_LANE_SCHEDULER_START_InLow,
    input  logic                SC_RANDOM_LANE_SCHEDULER_DOWN_InLow,
    input  logic [LEVEL_W-1:0]  SC_RANDOM_LANE_SCHEDULER_LEVEL_InLow,
`ifdef SC_RANDOM_LANE_SCHEDULER_PAUSE_EN
    input  logic                SC_RANDOM_LANE_SCHEDULER_PAUSE_InLow,
`endif
    output logic                SC_RANDOM_LANE_SCHEDULER_SELECTION,
    output logic [CHANNELS-1:0] SC_RANDOM_LANE_SCHEDULER_LANE,
    output logic                SC_RANDOM_LANE_SCHEDULER_BUSY
);

    localparam int         IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [7:0] SEED  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_READY      = 2'd2,
        ST_COUNT      = 2'd3
    } state_t;

    state_t              state_q;
    logic [LEVEL_W-1:0]  cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [7:0]          lfsr_q;
    logic [7:0]          lfsr_d;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    pick_idx;
    logic [CHANNELS-1:0] pick_onehot;
    logic                sel_q;
    logic                busy_q;
    logic [CHANNELS-1:0] lane_q;
    logic                run;

`ifdef SC_RANDOM_LANE_SCHEDULER_PAUSE_EN
    assign run = SC_RANDOM_LANE_SCHEDULER_PAUSE_InLow;
`else
    assign run = 1'b1;
`endif

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Bump a repeated candidate to the next lane; the index wraps naturally since CHANNELS is a power of two.
    always_comb begin
        cand     = lfsr_q[IDX_W-1:0];
        pick_idx = (cand == idx_q) ? cand + IDX_W'(1) : cand;
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge SC_RANDOM_LANE_SCHEDULER_CLOCK_50) begin
        if (SC_RANDOM_LANE_SCHEDULER_RESET_InHigh) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            lfsr_q  <= SEED;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            lane_q  <= CHANNELS'(1);
        end else if (!run) begin
            // Everything freezes; only the window indication is masked.
            sel_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_WAIT_START;
                    sel_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                ST_WAIT_START: begin
                    sel_q  <= 1'b0;
                    busy_q <= 1'b0;
                    if (!SC_RANDOM_LANE_SCHEDULER_START_InLow) begin
                        state_q <= ST_READY;
                        idx_q   <= pick_idx;
                        lane_q  <= pick_onehot;
                        sel_q   <= 1'b1;
                    end
                end
                ST_READY: begin
                    sel_q  <= 1'b1;
                    busy_q <= 1'b0;
                    if (!SC_RANDOM_LANE_SCHEDULER_DOWN_InLow &&
                        (SC_RANDOM_LANE_SCHEDULER_LEVEL_InLow != '0)) begin
                        state_q <= ST_COUNT;
                        cnt_q   <= SC_RANDOM_LANE_SCHEDULER_LEVEL_InLow;
                        sel_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    sel_q  <= 1'b0;
                    busy_q <= 1'b1;
                    if (!SC_RANDOM_LANE_SCHEDULER_DOWN_InLow) begin
                        if (cnt_q == LEVEL_W'(1)) begin
                            state_q <= ST_READY;
                            idx_q   <= pick_idx;
                            lane_q  <= pick_onehot;
                            sel_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - LEVEL_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sel_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign SC_RANDOM_LANE_SCHEDULER_SELECTION = sel_q;
    assign SC_RANDOM_LANE_SCHEDULER_BUSY      = busy_q;
    assign SC_RANDOM_LANE_SCHEDULER_LANE      = lane_q;

endmodule
